demux_1x8_deser: RTL and testbench
==================================

Name: demux_1x8_deser

Overview:
- Time-domain 1-to-8 demultiplexer: routes a serial bit stream into successive slots of a WIDTH-bit word, then presents the word on a valid/ready output.
- A slot counter plays the role of the select bus, advancing one slot per accepted bit.
- Sits downstream of serial links and bit-serial datapaths that feed the team's parallel select/mux logic.

Parameters:
- WIDTH, 8, number of slots per word; power of two, minimum 2.
- LSB_FIRST, 1, 1: first bit of a frame lands in slot 0; 0: first bit lands in slot WIDTH-1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- din  in  1  serial data bit.
- din_valid  in  1  din is accepted this cycle; no backpressure on input.
- frame_start  in  1  realign: discard partial word, restart at slot 0.
- dout  out  WIDTH  assembled word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready.
- cur_slot  out  $clog2(WIDTH)  slot index the next accepted bit will occupy.
- overrun  out  1  sticky: a completed word was dropped.
- parity_err  out  1  parity result for the current dout; tied 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at clk edge): cnt=0, acc=0, dout=0, dout_valid=0, overrun=0, parity_err=0, cur_slot=0. Reset mid-word discards the partial word and any held output.
- Slot mapping:
  - LSB_FIRST=1: slot = cnt.
  - LSB_FIRST=0: slot = WIDTH-1-cnt.
  - cur_slot = cnt.
- Accept (din_valid=1): acc[slot] <= din; cnt <= cnt+1.
- Completion: an accepted bit with cnt==WIDTH-1.
  - cnt wraps to 0 and acc clears to 0.
  - The completed word, including the final bit, is offered to the output stage.
  - Latency: final bit accepted in cycle N, so dout_valid=1 in cycle N+1.
- Gaps: din_valid=0 holds cnt and acc indefinitely.
- frame_start=1: cnt and acc clear.
  - If din_valid=1 in the same cycle, that bit is written to slot 0 (per the mapping) and cnt becomes 1.
  - frame_start takes priority over completion: no word is emitted that cycle.
- Output stage, two states EMPTY/FULL:
  - EMPTY + completion: load dout, go FULL (dout_valid=1).
  - FULL + dout_ready + no completion: go EMPTY; dout retains its last value.
  - FULL + dout_ready + completion in the same cycle: load the new word, stay FULL. No bubble, no overrun.
  - FULL + !dout_ready + completion: new word dropped, dout unchanged, overrun<=1.
- overrun clears only on rst.
- dout is stable while dout_valid=1 and dout_ready=0.

Optional Feature:
- Macro: DEMUX_PARITY_CHECK_EN.
- Defined:
  - A frame is WIDTH data bits plus one even-parity bit. Completion occurs on the parity bit (cnt==WIDTH).
  - The counter width grows by one bit; cur_slot reports WIDTH while the parity bit is expected.
  - parity_err = (^word) ^ parity_bit, loaded with dout and valid while dout_valid=1.
- Undefined: frame is WIDTH bits and parity_err is constant 0. Port list is identical in both builds.

Decomposition:
- Package demux_pkg holds:
  - SLOT_W = $clog2(WIDTH default).
  - Default WIDTH.
  - Output state enum out_state_e {OUT_EMPTY, OUT_FULL}.
- Sub-module demux_out_stage: holding register, EMPTY/FULL FSM, overrun and parity_err registers.
- Top level: slot counter, slot decode and accumulator.

Test Plan:
1. LSB_FIRST=1, dout_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> dout=8'h4D, dout_valid high one cycle, the cycle after the 8th bit; cur_slot back to 0.
2. LSB_FIRST=0, same stream -> dout=8'hB2; same stream with din_valid gaps of 3 cycles between bits -> identical result.
3. dout_ready=0, send 0x4D then 0xFF (16 bits) -> dout holds 8'h4D, overrun=1 the cycle after the 16th bit. Then dout_ready=1 for one cycle -> dout_valid=0, overrun stays 1.
4. Send 3 bits, pulse frame_start with din_valid=0, then send 0xA5 (LSB first) -> dout=8'hA5; the 3 stale bits are never emitted.
5. rst for 1 cycle after 5 bits of a word -> all outputs 0. Then send 0x3C -> dout=8'h3C.
6. DEMUX_PARITY_CHECK_EN defined: 0x4D with parity bit 0 -> parity_err=0; 0x4D with parity bit 1 -> parity_err=1; dout=8'h4D in both.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-8 deserializing demux (DEMUX_PARITY_CHECK_EN widens the slot counter)
package demux_pkg;

  localparam int DEMUX_WIDTH = 8;
  localparam int SLOT_W      = $clog2(DEMUX_WIDTH);

`ifdef DEMUX_PARITY_CHECK_EN
  // One extra counter bit so the parity slot (index WIDTH) is representable
  localparam int CNT_EXTRA = 1;
`else
  localparam int CNT_EXTRA = 0;
`endif

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/demux_out_stage.sv
// rtl/demux_out_stage.sv - word holding register with EMPTY/FULL handshake, sticky overrun and parity flag
module demux_out_stage
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             complete,
  input  logic [WIDTH-1:0] word,
  input  logic             par_in,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun,
  output logic             parity_err
);

  out_state_e state_q, state_d;
  logic       load_en;
  logic       ovr_set;

  // Next-state and load/drop decisions for the holding register
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          load_en = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete) begin
          // Consumer draining in the same cycle frees the slot for the new word
          if (dout_ready) load_en = 1'b1;
          else            ovr_set = 1'b1;
        end else if (dout_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // State, holding register, sticky overrun and parity result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OUT_EMPTY;
      dout       <= '0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        dout       <= word;
        parity_err <= par_in;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

  assign dout_valid = (state_q == OUT_FULL);

endmodule

// File: rtl/demux_1x8_deser.sv
// rtl/demux_1x8_deser.sv - serial-to-parallel time-domain demux: slot counter, slot decode, accumulator (DEMUX_PARITY_CHECK_EN adds a trailing even-parity bit)
module demux_1x8_deser
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEMUX_WIDTH,
  parameter int LSB_FIRST = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                din,
  input  logic                                din_valid,
  input  logic                                frame_start,
  output logic [WIDTH-1:0]                    dout,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic [$clog2(WIDTH)+CNT_EXTRA-1:0]  cur_slot,
  output logic                                overrun,
  output logic                                parity_err
);

  localparam int            SW       = $clog2(WIDTH);
  localparam int            CW       = SW + CNT_EXTRA;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1 + CNT_EXTRA);
  localparam logic [SW-1:0] TOP_SLOT = SW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [SW-1:0]    slot;
  logic [SW-1:0]    first_slot;
  logic             data_slot;
  logic             complete;
  logic             par_in;

`ifdef DEMUX_PARITY_CHECK_EN
  // Counter MSB is set only while the parity bit is expected
  assign data_slot = ~cnt[CW-1];
  assign par_in    = (^word) ^ din;
`else
  assign data_slot = 1'b1;
  assign par_in    = 1'b0;
`endif

  // Slot decode: the counter acts as the select bus, mirrored for MSB-first framing
  always_comb begin
    slot       = (LSB_FIRST != 0) ? cnt[SW-1:0] : TOP_SLOT - cnt[SW-1:0];
    first_slot = (LSB_FIRST != 0) ? '0 : TOP_SLOT;
  end

  // Accumulator with the current bit merged in; this is also the completed word
  always_comb begin
    word = acc;
    if (data_slot) word[slot] = din;
  end

  // Realign wins over completion, so a frame_start cycle never emits a word
  assign complete = din_valid & ~frame_start & (cnt == LAST_CNT);

  // Slot counter and accumulator update
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (frame_start) begin
      cnt <= din_valid ? CW'(1) : '0;
      acc <= din_valid ? ({{(WIDTH-1){1'b0}}, din} << first_slot) : '0;
    end else if (din_valid) begin
      if (complete) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + CW'(1);
        acc <= word;
      end
    end
  end

  assign cur_slot = cnt;

  demux_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .complete  (complete),
    .word      (word),
    .par_in    (par_in),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

endmodule

// File: tb/tb_demux_1x8_deser.sv
// tb/tb_demux_1x8_deser.sv - bench for demux_1x8_deser, LSB-first and MSB-first instances on one stream (DEMUX_PARITY_CHECK_EN aware)
module tb_demux_1x8_deser;

  localparam int W = 8;
`ifdef DEMUX_PARITY_CHECK_EN
  localparam int FRAME = W + 1;
  localparam int CW    = 4;
`else
  localparam int FRAME = W;
  localparam int CW    = 3;
`endif

  logic          clk;
  logic          rst;
  logic          din;
  logic          din_valid;
  logic          frame_start;
  logic          dout_ready;
  logic [W-1:0]  dout_l, dout_m;
  logic          valid_l, valid_m;
  logic [CW-1:0] slot_l, slot_m;
  logic          ovr_l, ovr_m;
  logic          perr_l, perr_m;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  demux_1x8_deser #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .cur_slot(slot_l), .overrun(ovr_l), .parity_err(perr_l)
  );

  demux_1x8_deser #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .cur_slot(slot_m), .overrun(ovr_m), .parity_err(perr_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // Model: the frame is just the list of bits received since the last boundary
  bit           mq[$];
  logic [W-1:0] m_dout_l = '0;
  logic [W-1:0] m_dout_m = '0;
  logic         m_valid  = 1'b0;
  logic         m_ovr    = 1'b0;
  logic         m_perr   = 1'b0;

  always @(posedge clk) begin : model
    bit           comp;
    logic [W-1:0] wl, wm;
    logic         pe;
    comp = 0;
    wl   = '0;
    wm   = '0;
    pe   = 1'b0;
    if (rst) begin
      mq.delete();
      m_valid  = 1'b0;
      m_dout_l = '0;
      m_dout_m = '0;
      m_ovr    = 1'b0;
      m_perr   = 1'b0;
    end else begin
      if (frame_start) begin
        mq.delete();
        if (din_valid) mq.push_back(din);
      end else if (din_valid) begin
        mq.push_back(din);
        if (mq.size() == FRAME) begin
          comp = 1;
          for (int i = 0; i < W; i++) begin
            wl = wl + (W'(mq[i]) << i);
            wm = wm + (W'(mq[i]) << (W - 1 - i));
          end
`ifdef DEMUX_PARITY_CHECK_EN
          pe = (^wl) ^ mq[W];
`endif
          mq.delete();
        end
      end
      if (comp) begin
        if (!m_valid || dout_ready) begin
          m_dout_l = wl;
          m_dout_m = wm;
          m_perr   = pe;
          m_valid  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && dout_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("dout_l", dout_l, m_dout_l);
      check("dout_m", dout_m, m_dout_m);
      check("valid_l", valid_l, m_valid);
      check("valid_m", valid_m, m_valid);
      check("slot_l", slot_l, mq.size());
      check("slot_m", slot_m, mq.size());
      check("ovr_l", ovr_l, m_ovr);
      check("ovr_m", ovr_m, m_ovr);
      check("perr_l", perr_l, m_perr);
      check("perr_m", perr_m, m_perr);
    end
  end

  task automatic cyc(input logic v, input logic b, input logic fs);
    din_valid   = v;
    din         = b;
    frame_start = fs;
    @(negedge clk);
  endtask

  // Sends w LSB-first (plus parity bit pb in the parity build); rl is dout_ready on the final bit
  task automatic send_frame(input logic [7:0] w, input logic pb, input int gap, input logic rl);
    logic [7:0] wv;
    wv = w;
    for (int i = 0; i < W; i++) begin
      if (i > 0) repeat (gap) cyc(1'b0, 1'b0, 1'b0);
      if (i == W - 1 && FRAME == W) dout_ready = rl;
      cyc(1'b1, wv[i], 1'b0);
    end
`ifdef DEMUX_PARITY_CHECK_EN
    dout_ready = rl;
    cyc(1'b1, pb, 1'b0);
`else
    if (pb) wv = w;
`endif
  endtask

  initial begin
    rst         = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    dout_ready  = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_en = 1;
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_dout", dout_l, 8'h00);
    check("rst_valid", valid_l, 1'b0);
    check("rst_slot", slot_l, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // Basic frame, both bit orders
    send_frame(8'h4D, 1'b0, 0, 1'b1);
    check("t1_dout_l", dout_l, 8'h4D);
    check("t1_model_l", m_dout_l, 8'h4D);
    check("t2_dout_m", dout_m, 8'hB2);
    check("t2_model_m", m_dout_m, 8'hB2);
    check("t1_valid", valid_l, 1'b1);
    check("t1_slot", slot_l, 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t1_valid_one_cycle", valid_l, 1'b0);

    // Same stream with 3-cycle gaps
    send_frame(8'h4D, 1'b0, 3, 1'b1);
    check("t2_gap_dout_m", dout_m, 8'hB2);
    check("t2_gap_dout_l", dout_l, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0);

    // Overrun: consumer stalled across two frames
    dout_ready = 1'b0;
    send_frame(8'h4D, 1'b0, 0, 1'b0);
    send_frame(8'hFF, 1'b0, 0, 1'b0);
    check("t3_dout_held", dout_l, 8'h4D);
    check("t3_overrun", ovr_l, 1'b1);
    check("t3_valid", valid_l, 1'b1);
    dout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("t3_valid_drained", valid_l, 1'b0);
    check("t3_overrun_sticky", ovr_l, 1'b1);

    // Realign discards a partial word
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("t4_slot_realign", slot_l, 0);
    send_frame(8'hA5, 1'b0, 0, 1'b1);
    check("t4_dout", dout_l, 8'hA5);
    check("t4_model", m_dout_l, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0);

    // Realign with a bit in the same cycle: that bit becomes slot 0
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("t4b_slot_one", slot_l, 1);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 2; i < W; i++) cyc(1'b1, 1'b0, 1'b0);
`ifdef DEMUX_PARITY_CHECK_EN
    cyc(1'b1, 1'b0, 1'b0);
`endif
    check("t4b_dout_l", dout_l, 8'h03);
    check("t4b_dout_m", dout_m, 8'hC0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset mid-word clears everything including sticky overrun
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("t5_dout", dout_l, 8'h00);
    check("t5_valid", valid_l, 1'b0);
    check("t5_overrun", ovr_l, 1'b0);
    check("t5_slot", slot_l, 0);
    check("t5_perr", perr_l, 1'b0);
    send_frame(8'h3C, 1'b0, 0, 1'b1);
    check("t5_dout_3c", dout_l, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0);

    // FULL with ready and completion in the same cycle: no bubble, no overrun
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 0, 1'b0);
    check("t7_first", dout_l, 8'h11);
    send_frame(8'h22, 1'b0, 0, 1'b1);
    check("t7_second", dout_l, 8'h22);
    check("t7_valid", valid_l, 1'b1);
    check("t7_no_overrun", ovr_l, 1'b0);
    dout_ready = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

`ifdef DEMUX_PARITY_CHECK_EN
    send_frame(8'h4D, 1'b0, 0, 1'b1);
    check("t6_perr_ok", perr_l, 1'b0);
    check("t6_dout_a", dout_l, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0);
    send_frame(8'h4D, 1'b1, 0, 1'b1);
    check("t6_perr_bad", perr_l, 1'b1);
    check("t6_model_perr", m_perr, 1'b1);
    check("t6_dout_b", dout_l, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0);
`endif

    cyc(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
